gate_sweep_checker: RTL and testbench
=====================================

// Module: gate_sweep_checker
// PURPOSE
//  Self-checking exhaustive stimulus engine for N-input NAND/NOR/XOR/XNOR gates.
//  On start it drives every input vector 0..2^N-1 to a gate under test and holds each for HOLD cycles.
//  On the last hold cycle it compares the gate's output against an internal reference and counts mismatches.
//  It sits beside the gate under test in week-level bring-up benches and replaces per-bit toggle stimulus.
// PARAMETERS
//  N     4  number of gate inputs, 2..16
//  HOLD  1  cycles each vector is held before sampling, >=1
// PORTS
//  clk        in   1    rising-edge clock
//  rst        in   1    synchronous, active-high reset
//  start      in   1    begin sweep; sampled only in IDLE or DONE
//  mode       in   2    00 NAND, 01 NOR, 10 XOR, 11 XNOR; latched on accepted start
//  dut_y      in   1    output of gate under test, driven from vec
//  vec        out  N    current input vector to gate under test
//  ref_y      out  1    expected output for vec under the latched mode
//  busy       out  1    high while in RUN
//  done       out  1    high in DONE until the next accepted start or rst
//  err_count  out  N+1  mismatch count, saturates at 2^(N+1)-1
// BEHAVIOUR
//  Reset: one clock and synchronous active-high reset; rst sampled high on a rising edge forces state to IDLE
//   and sets vec=0, busy=0, done=0, err_count=0, hold_cnt=0, mode_q=00.
//  Reset mid-sweep aborts the sweep immediately; no partial done is signalled.
//  FSM states: IDLE, RUN and DONE.
//  IDLE -> RUN on start=1. The same edge latches mode_q, clears vec, hold_cnt and err_count, and sets busy=1.
//  RUN: hold_cnt increments each cycle from 0 to HOLD-1. Each cycle with hold_cnt==HOLD-1 is a sample cycle:
//   - if dut_y != ref_y, err_count increments (saturating);
//   - if vec == {N{1'b1}}, go to DONE, set busy=0 and done=1, and keep vec at all-ones;
//   - otherwise vec <= vec+1 and hold_cnt <= 0.
//  DONE -> RUN on start=1, with the same clears as from IDLE; done drops on that edge.
//  start is ignored while in RUN.
//  ref_y is a pure function of registered vec and mode_q:
//   NAND ~&vec, NOR ~|vec, XOR ^vec, XNOR ~^vec. There is no combinational path from inputs to outputs.
//  dut_y is sampled only on sample cycles; other cycles give the gate HOLD-1 cycles to settle.
//  Sweep length is exactly 2^N*HOLD cycles in RUN. The first vector is presented on the cycle after start.
//  A change on mode during RUN has no effect; only mode_q is used.
// CONFIGURATION
//  FIRST_FAIL_CAPTURE_EN defined:
//   - adds output fail_seen (1b) and output fail_vec (N).
//   - on the first mismatching sample of a sweep, fail_vec <= vec and fail_seen <= 1.
//   - later mismatches do not overwrite them.
//   - both clear on rst and on an accepted start.
//  FIRST_FAIL_CAPTURE_EN undefined: those ports and registers do not exist; all other behaviour is identical.
// TESTING
//  1 N=4,HOLD=1, mode=00, dut_y tied to correct NAND -> busy 16 cycles, vec 0..15, done=1, err_count=0.
//  2 N=4,HOLD=2, mode=10, dut_y=~^vec (inverted) -> 32 RUN cycles, err_count=16, done=1.
//  3 N=4, mode=01, dut_y forced 0 -> exactly one mismatch (vec=0, ref 1), err_count=1;
//    with FIRST_FAIL_CAPTURE_EN: fail_vec=4'h0, fail_seen=1.
//  4 rst asserted while vec=4'h7 in RUN -> next cycle state IDLE, vec=0, busy=0, done=0, err_count=0.
//  5 start pulsed during RUN and mode changed to 11 mid-sweep -> sweep unaffected, ref_y stays under mode 00;
//    start in DONE restarts with err_count=0 and the new mode.
//  6 N=2,HOLD=1, mode=11, dut_y=~^vec -> 4 RUN cycles, err_count=0;
//    repeat with dut_y=1 -> err_count=2 (vec 1 and 2).

Source files
------------

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep stimulus and self-check for an N-input NAND/NOR/XOR/XNOR gate.
// Optional first-failure capture (fail_seen/fail_vec) is enabled by defining FIRST_FAIL_CAPTURE_EN.
module gate_sweep_checker #(
  parameter int N    = 4,
  parameter int HOLD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         dut_y,
  output logic [N-1:0] vec,
  output logic         ref_y,
  output logic         busy,
  output logic         done,
  output logic [N:0]   err_count
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic         fail_seen,
  output logic [N-1:0] fail_vec
`endif
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [N-1:0]  VEC_LAST  = '1;
  localparam logic [N:0]    ERR_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  vec_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N:0]    err_d;
  logic [1:0]    mode_q, mode_d;
  logic          busy_d, done_d;
  logic          sample, mismatch;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic          fail_seen_d;
  logic [N-1:0]  fail_vec_d;
`endif

  function automatic logic [N:0] sat_inc(input logic [N:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic ref_fn(input logic [N-1:0] v, input logic [1:0] m);
    logic r;
    case (m)
      2'b00:   r = ~&v;
      2'b01:   r = ~|v;
      2'b10:   r = ^v;
      default: r = ~^v;
    endcase
    return r;
  endfunction

  // Reference depends only on registered state, so there is no input-to-output path.
  assign ref_y    = ref_fn(vec, mode_q);
  assign sample   = (state_q == RUN) && (hold_q == HOLD_LAST);
  assign mismatch = sample && (dut_y != ref_y);

  always_comb begin
    state_d = state_q;
    vec_d   = vec;
    hold_d  = hold_q;
    err_d   = err_count;
    mode_d  = mode_q;
    busy_d  = busy;
    done_d  = done;
`ifdef FIRST_FAIL_CAPTURE_EN
    fail_seen_d = fail_seen;
    fail_vec_d  = fail_vec;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          vec_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
          fail_seen_d = 1'b0;
          fail_vec_d  = '0;
`endif
        end
      end
      RUN: begin
        if (sample) begin
          if (mismatch) begin
            err_d = sat_inc(err_count);
`ifdef FIRST_FAIL_CAPTURE_EN
            if (!fail_seen) begin
              fail_seen_d = 1'b1;
              fail_vec_d  = vec;
            end
`endif
          end
          // The last vector stays on the bus after the sweep ends.
          if (vec == VEC_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d  = vec + 1'b1;
            hold_d = '0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec       <= '0;
      hold_q    <= '0;
      err_count <= '0;
      mode_q    <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
      fail_seen <= 1'b0;
      fail_vec  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      vec       <= vec_d;
      hold_q    <= hold_d;
      err_count <= err_d;
      mode_q    <= mode_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef FIRST_FAIL_CAPTURE_EN
      fail_seen <= fail_seen_d;
      fail_vec  <= fail_vec_d;
`endif
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances (N4/H1, N4/H2, N2/H1) checked every cycle
// against a sweep-time model, plus directed scenarios with literal expectations.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v[3];
  logic [1:0] mode_v[3];
  logic       dy[3];
  int         beh[3];
  bit         en = 1'b0;

  logic [3:0] vec_a, vec_b;
  logic [1:0] vec_c;
  logic       ref_a, ref_b, ref_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [4:0] err_a, err_b;
  logic [2:0] err_c;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic       fs_a, fs_b, fs_c;
  logic [3:0] fv_a, fv_b;
  logic [1:0] fv_c;
  int         dfs[3], dfv[3];
`endif

  int dv[3], dr[3], db[3], dd[3], de[3];
  int m_st[3], m_t[3], m_mode[3], m_err[3], m_fs[3], m_fv[3];
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  gate_sweep_checker #(.N(4), .HOLD(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]), .dut_y(dy[0]),
    .vec(vec_a), .ref_y(ref_a), .busy(busy_a), .done(done_a), .err_count(err_a)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_seen(fs_a), .fail_vec(fv_a)
`endif
  );
  gate_sweep_checker #(.N(4), .HOLD(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]), .dut_y(dy[1]),
    .vec(vec_b), .ref_y(ref_b), .busy(busy_b), .done(done_b), .err_count(err_b)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_seen(fs_b), .fail_vec(fv_b)
`endif
  );
  gate_sweep_checker #(.N(2), .HOLD(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode_v[2]), .dut_y(dy[2]),
    .vec(vec_c), .ref_y(ref_c), .busy(busy_c), .done(done_c), .err_count(err_c)
`ifdef FIRST_FAIL_CAPTURE_EN
    , .fail_seen(fs_c), .fail_vec(fv_c)
`endif
  );

  function automatic int np(input int i);
    return (i == 2) ? 2 : 4;
  endfunction

  function automatic int hp(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  // kind: 0 NAND, 1 NOR, 2 XOR, 3 XNOR, 4 constant 0, 5 constant 1
  function automatic logic gate(input int v, input int n, input int kind);
    int mask, x, par;
    mask = (1 << n) - 1;
    x    = v & mask;
    par  = $countones(x) & 1;
    case (kind)
      0:       return x != mask;
      1:       return x == 0;
      2:       return par == 1;
      3:       return par == 0;
      4:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int m_vec(input int i);
    if (m_st[i] == 1) return m_t[i] / hp(i);
    if (m_st[i] == 2) return (1 << np(i)) - 1;
    return 0;
  endfunction

  always_comb begin
    dv[0] = int'(vec_a);  dv[1] = int'(vec_b);  dv[2] = int'(vec_c);
    dr[0] = int'(ref_a);  dr[1] = int'(ref_b);  dr[2] = int'(ref_c);
    db[0] = int'(busy_a); db[1] = int'(busy_b); db[2] = int'(busy_c);
    dd[0] = int'(done_a); dd[1] = int'(done_b); dd[2] = int'(done_c);
    de[0] = int'(err_a);  de[1] = int'(err_b);  de[2] = int'(err_c);
`ifdef FIRST_FAIL_CAPTURE_EN
    dfs[0] = int'(fs_a); dfs[1] = int'(fs_b); dfs[2] = int'(fs_c);
    dfv[0] = int'(fv_a); dfv[1] = int'(fv_b); dfv[2] = int'(fv_c);
`endif
  end

  // Gate under test: behaviour selected per instance by beh[].
  always_comb begin
    for (int i = 0; i < 3; i++) dy[i] = gate(dv[i], np(i), beh[i]);
  end

  task automatic chk(input string nm, input int i, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[inst %0d] got=%0d expected=%0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Model: m_t counts cycles since the sweep began; vector = m_t/HOLD.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_st[i] = 0; m_t[i] = 0; m_mode[i] = 0; m_err[i] = 0; m_fs[i] = 0; m_fv[i] = 0;
      end else if (m_st[i] != 1) begin
        if (start_v[i]) begin
          m_st[i] = 1; m_t[i] = 0; m_mode[i] = int'(mode_v[i]);
          m_err[i] = 0; m_fs[i] = 0; m_fv[i] = 0;
        end
      end else if (m_t[i] % hp(i) == hp(i) - 1) begin
        int v;
        v = m_t[i] / hp(i);
        if (gate(v, np(i), beh[i]) != gate(v, np(i), m_mode[i])) begin
          if (m_err[i] < (1 << (np(i) + 1)) - 1) m_err[i]++;
          if (m_fs[i] == 0) begin
            m_fs[i] = 1; m_fv[i] = v;
          end
        end
        if (v == (1 << np(i)) - 1) m_st[i] = 2;
        else m_t[i]++;
      end else begin
        m_t[i]++;
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      for (int i = 0; i < 3; i++) begin
        chk("vec", i, dv[i], m_vec(i));
        chk("ref_y", i, dr[i], int'(gate(m_vec(i), np(i), m_mode[i])));
        chk("busy", i, db[i], int'(m_st[i] == 1));
        chk("done", i, dd[i], int'(m_st[i] == 2));
        chk("err_count", i, de[i], m_err[i]);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("fail_seen", i, dfs[i], m_fs[i]);
        chk("fail_vec", i, dfv[i], m_fv[i]);
`endif
      end
    end
  end

  task automatic run(input int i, input int md, input int bh, output int cyc);
    mode_v[i]  = md[1:0];
    beh[i]     = bh;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    cyc = 0;
    while (dd[i] == 0 && cyc < 200) begin
      if (db[i] != 0) cyc++;
      @(negedge clk);
    end
    if (dd[i] == 0) chk("run_timeout", i, dd[i], 1);
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; mode_v[i] = 2'b00; beh[i] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Reset state
    chk("lit_rst_vec", 0, dv[0], 0);
    chk("lit_rst_busy", 0, db[0], 0);
    chk("lit_rst_done", 0, dd[0], 0);
    chk("lit_rst_err", 0, de[0], 0);
    chk("lit_rst_ref", 0, dr[0], 1);

    // 1: N4 H1 NAND, correct gate
    run(0, 0, 0, cyc);
    chk("lit_t1_cycles", 0, cyc, 16);
    chk("lit_t1_err", 0, de[0], 0);
    chk("lit_t1_vec", 0, dv[0], 15);

    // 2: N4 H2 XOR, gate is XNOR
    run(1, 2, 3, cyc);
    chk("lit_t2_cycles", 1, cyc, 32);
    chk("lit_t2_err", 1, de[1], 16);

    // 3: NOR, dut stuck at 0
    run(0, 1, 4, cyc);
    chk("lit_t3_err", 0, de[0], 1);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk("lit_t3_fail_vec", 0, dfv[0], 0);
    chk("lit_t3_fail_seen", 0, dfs[0], 1);
`endif

    // 6: N2 XNOR, correct then stuck at 1
    run(2, 3, 3, cyc);
    chk("lit_t6_cycles", 2, cyc, 4);
    chk("lit_t6_err", 2, de[2], 0);
    run(2, 3, 5, cyc);
    chk("lit_t6_err_stuck1", 2, de[2], 2);

    // 4: reset mid-sweep at vec 7
    mode_v[0] = 2'b00; beh[0] = 0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    cyc = 0;
    while (dv[0] != 7 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    chk("lit_t4_reach7", 0, dv[0], 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("lit_t4_vec", 0, dv[0], 0);
    chk("lit_t4_busy", 0, db[0], 0);
    chk("lit_t4_done", 0, dd[0], 0);
    chk("lit_t4_err", 0, de[0], 0);
    chk("lit_t4_other_done", 1, dd[1], 0);

    // 5: start and mode change during RUN are ignored
    mode_v[0] = 2'b00; beh[0] = 0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    mode_v[0]  = 2'b11;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    cyc = 0;
    while (dd[0] == 0 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    chk("lit_t5_done", 0, dd[0], 1);
    chk("lit_t5_err", 0, de[0], 0);
    chk("lit_t5_ref_nand15", 0, dr[0], 0);
    run(0, 3, 4, cyc);
    chk("lit_t5_restart_cycles", 0, cyc, 16);
    chk("lit_t5_restart_err", 0, de[0], 8);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
